// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction codes and sequencer state encoding.
// Used by the sequencer and by instruction-decode consumers.
package cpu_pkg;

    localparam int unsigned INST_W      = 7;
    localparam int unsigned RETIRED_W   = 32;
    localparam int unsigned STALL_CNT_W = 8;

    typedef logic [INST_W-1:0] instcode_t;

    localparam instcode_t INST_ADDU = 7'd4;
    localparam instcode_t INST_DIV  = 7'd7;
    localparam instcode_t INST_DIVU = 7'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC1    = 3'd2,
        ST_DIV_WAIT = 3'd3,
        ST_EXEC2    = 3'd4,
        ST_HALTED   = 3'd5
    } seq_state_t;

    function automatic logic is_div(input instcode_t code);
        return (code == INST_DIV) || (code == INST_DIVU);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles; trip_c fires in the stall cycle that
// brings the run length up to STALL_LIMIT.
module stall_watchdog
    import cpu_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic trip_c
);

    logic [STALL_CNT_W-1:0] count;
    logic [STALL_CNT_W:0]   run_len_c;

    // Run length including the current cycle.
    assign run_len_c = {1'b0, count} + (STALL_CNT_W + 1)'(1);
    assign trip_c    = stall && (32'(run_len_c) >= STALL_LIMIT);

    // Saturates so a very long stall cannot wrap back under the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!stall) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/EXEC1/(DIV_WAIT)/EXEC2 per
// instruction, retired-instruction counter and stall watchdog.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 waitrequest,
    input  logic                 mem_access,
    input  logic [INST_W-1:0]    instruction_code,
    input  logic                 div_done,
    input  logic                 halt_req,
    output logic                 fetch,
    output logic                 exec1,
    output logic                 exec2,
    output logic                 stall,
    output logic                 active,
    output logic                 error,
    output logic [RETIRED_W-1:0] retired
);

    seq_state_t state;
    seq_state_t next_state;
    logic       trip_c;
    logic       mem_hold_c;
    logic       exit_c;

    assign mem_hold_c = mem_access && waitrequest;
    assign exit_c     = (state == ST_EXEC2) && !mem_hold_c && !trip_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Watchdog overrides every normal transition.
    always_comb begin
        next_state = state;
        if (trip_c) begin
            next_state = ST_HALTED;
        end else begin
            case (state)
                ST_IDLE:     next_state = ST_FETCH;
                ST_FETCH:    if (!waitrequest) next_state = ST_EXEC1;
                ST_EXEC1:    next_state = is_div(instcode_t'(instruction_code)) ? ST_DIV_WAIT : ST_EXEC2;
                ST_DIV_WAIT: if (div_done) next_state = ST_EXEC2;
                ST_EXEC2:    if (!mem_hold_c) next_state = halt_req ? ST_HALTED : ST_FETCH;
                ST_HALTED:   next_state = ST_HALTED;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch  = 1'b0;
        exec1  = 1'b0;
        exec2  = 1'b0;
        stall  = 1'b0;
        active = 1'b1;
        case (state)
            ST_FETCH: begin
                fetch = 1'b1;
                stall = waitrequest;
            end
            ST_EXEC1:    exec1 = 1'b1;
            ST_DIV_WAIT: stall = !div_done;
            ST_EXEC2: begin
                exec2 = 1'b1;
                stall = mem_hold_c;
            end
            ST_HALTED:   active = 1'b0;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            error   <= 1'b0;
        end else begin
            if (exit_c) begin
                retired <= retired + RETIRED_W'(1);
            end
            if (trip_c) begin
                error <= 1'b1;
            end
        end
    end

    stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (stall),
        .trip_c (trip_c)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_cpu_sequencer;

    localparam int unsigned LIMIT = 255;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC1 = 2;
    localparam int P_DIVW  = 3;
    localparam int P_EXEC2 = 4;
    localparam int P_HALT  = 5;

    logic        clk;
    logic        rst_n;
    logic        waitrequest;
    logic        mem_access;
    logic [6:0]  instruction_code;
    logic        div_done;
    logic        halt_req;
    logic        fetch;
    logic        exec1;
    logic        exec2;
    logic        stall;
    logic        active;
    logic        error;
    logic [31:0] retired;

    int compared   = 0;
    int mismatched = 0;

    int          m_phase;
    int          m_run;
    logic        m_err;
    logic [31:0] m_ret;

    cpu_sequencer #(.STALL_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .waitrequest      (waitrequest),
        .mem_access       (mem_access),
        .instruction_code (instruction_code),
        .div_done         (div_done),
        .halt_req         (halt_req),
        .fetch            (fetch),
        .exec1            (exec1),
        .exec2            (exec2),
        .stall            (stall),
        .active           (active),
        .error            (error),
        .retired          (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Stall condition as a function of where the instruction is.
    function automatic bit model_stall();
        case (m_phase)
            P_FETCH: return waitrequest == 1'b1;
            P_DIVW:  return div_done == 1'b0;
            P_EXEC2: return (mem_access && waitrequest) == 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_run   = 0;
            m_err   = 1'b0;
            m_ret   = 32'd0;
        end else begin
            bit st;
            st = model_stall();
            if (st && (m_run + 1 >= int'(LIMIT))) begin
                m_err   = 1'b1;
                m_phase = P_HALT;
                m_run   = 0;
            end else begin
                m_run = st ? m_run + 1 : 0;
                case (m_phase)
                    P_IDLE:  m_phase = P_FETCH;
                    P_FETCH: if (!waitrequest) m_phase = P_EXEC1;
                    P_EXEC1: m_phase = (instruction_code == 7'd7 || instruction_code == 7'd8) ? P_DIVW : P_EXEC2;
                    P_DIVW:  if (div_done) m_phase = P_EXEC2;
                    P_EXEC2: if (!(mem_access && waitrequest)) begin
                        m_ret   = m_ret + 32'd1;
                        m_phase = halt_req ? P_HALT : P_FETCH;
                    end
                    default: m_phase = P_HALT;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk1("fetch",   fetch,   m_phase == P_FETCH);
        chk1("exec1",   exec1,   m_phase == P_EXEC1);
        chk1("exec2",   exec2,   m_phase == P_EXEC2);
        chk1("stall",   stall,   model_stall());
        chk1("active",  active,  m_phase != P_HALT);
        chk1("error",   error,   m_err);
        chk32("retired", retired, m_ret);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nf;
        int ns;
        int nd;
        rst_n            = 1'b0;
        waitrequest      = 1'b0;
        mem_access       = 1'b0;
        instruction_code = 7'd4;
        div_done         = 1'b0;
        halt_req         = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk1("rst_fetch", fetch, 1'b0);
        chk1("rst_exec1", exec1, 1'b0);
        chk1("rst_exec2", exec2, 1'b0);
        chk1("rst_active", active, 1'b1);
        chk1("rst_error", error, 1'b0);
        chk32("rst_retired", retired, 32'd0);

        // Plain ADDU round trip.
        tick(); chk1("addu_fetch", fetch, 1'b1);
        tick(); chk1("addu_exec1", exec1, 1'b1);
        tick(); chk1("addu_exec2", exec2, 1'b1);
        tick(); chk1("addu_back_fetch", fetch, 1'b1);
        chk32("addu_retired", retired, 32'd1);

        // Fetch held three cycles by waitrequest.
        nf = 0; ns = 0;
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            #1;
            nf += int'(fetch);
            ns += int'(stall);
            tick();
        end
        waitrequest = 1'b0;
        chk32("fwait_fetch_cycles", 32'(nf), 32'd4);
        chk32("fwait_stall_cycles", 32'(ns), 32'd3);
        chk1("fwait_exec1", exec1, 1'b1);

        // DIV with divider finishing after five wait cycles.
        instruction_code = 7'd7;
        tick();
        ns = 0; nd = 0;
        for (int i = 0; i < 6; i++) begin
            div_done = (i == 5);
            #1;
            ns += int'(stall);
            nd += int'(fetch | exec1 | exec2);
            tick();
        end
        div_done = 1'b0;
        chk32("div_stall_cycles", 32'(ns), 32'd5);
        chk32("div_decodes_low", 32'(nd), 32'd0);
        chk1("div_exec2", exec2, 1'b1);
        instruction_code = 7'd4;
        tick();
        chk32("div_retired", retired, 32'd2);

        // Memory wait plus halt request in EXEC2.
        tick(); tick();
        chk1("halt_exec2", exec2, 1'b1);
        mem_access = 1'b1;
        halt_req   = 1'b1;
        ns = 0;
        for (int i = 0; i < 3; i++) begin
            waitrequest = (i < 2);
            #1;
            ns += int'(stall);
            tick();
        end
        chk32("halt_stall_cycles", 32'(ns), 32'd2);
        chk1("halt_active", active, 1'b0);
        chk32("halt_retired", retired, 32'd3);
        mem_access = 1'b0; halt_req = 1'b0; waitrequest = 1'b0;
        tick();
        chk1("halt_terminal", active, 1'b0);

        // Reset in the middle of a divide after ten retirements.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick(); tick(); tick();
        end
        instruction_code = 7'd8;
        tick(); tick();
        #1;
        chk1("midrst_in_divwait", stall, 1'b1);
        chk32("midrst_retired_before", retired, 32'd10);
        rst_n = 1'b0;
        #1;
        chk1("midrst_fetch", fetch, 1'b0);
        chk1("midrst_exec2", exec2, 1'b0);
        chk1("midrst_active", active, 1'b1);
        chk1("midrst_error", error, 1'b0);
        chk32("midrst_retired", retired, 32'd0);

        // Watchdog: waitrequest stuck high in FETCH.
        instruction_code = 7'd4;
        waitrequest      = 1'b1;
        rst_n            = 1'b1;
        tick();
        for (int i = 1; i < 255; i++) tick();
        #1;
        chk1("wd_fetch_255th", fetch, 1'b1);
        chk1("wd_stall_255th", stall, 1'b1);
        chk1("wd_error_pre", error, 1'b0);
        tick();
        chk1("wd_error_set", error, 1'b1);
        chk1("wd_halted", active, 1'b0);
        chk1("wd_fetch_low", fetch, 1'b0);
        waitrequest = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk1("wd_error_cleared", error, 1'b0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            waitrequest = ($urandom_range(0, 2) == 0);
            mem_access  = ($urandom_range(0, 1) == 0);
            div_done    = ($urandom_range(0, 3) == 0);
            halt_req    = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       instruction_code = 7'd7;
                1:       instruction_code = 7'd8;
                2:       instruction_code = 7'd4;
                default: instruction_code = 7'($urandom_range(0, 127));
            endcase
            rst_n = !(m_phase == P_HALT || $urandom_range(0, 299) == 0);
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255: max consecutive stall cycles before watchdog error.
REQ-002 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port waitrequest  input  1  memory bus busy; current access not yet accepted.
REQ-005 SHALL have port mem_access  input  1  current instruction uses data memory in EXEC2 (load/store).
REQ-006 SHALL have port instruction_code  input  7  decoded instruction code, valid during EXEC1/EXEC2.
REQ-007 SHALL have port div_done  input  1  divider result ready.
REQ-008 SHALL have port halt_req  input  1  next PC is address 0; sampled only in EXEC2.
REQ-009 SHALL have port fetch  output  1  high in FETCH state.
REQ-010 SHALL have port exec1  output  1  high in EXEC1 state.
REQ-011 SHALL have port exec2  output  1  high in EXEC2 state.
REQ-012 SHALL have port stall  output  1  high in any cycle the state is held by waitrequest or divider.
REQ-013 SHALL have port active  output  1  low only in HALTED.
REQ-014 SHALL have port error  output  1  sticky watchdog error flag.
REQ-015 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC1, DIV_WAIT, EXEC2, HALTED.
REQ-017 IDLE SHALL go to FETCH unconditionally on the next clock edge.
REQ-018 FETCH SHALL hold while waitrequest=1, else go to EXEC1.
REQ-019 EXEC1 SHALL go to DIV_WAIT if instruction_code is DIV (7) or DIVU (8), else to EXEC2.
REQ-020 DIV_WAIT SHALL hold until div_done=1, then go to EXEC2; div_done in other states is ignored.
REQ-021 EXEC2 SHALL hold while mem_access=1 and waitrequest=1; waitrequest with mem_access=0 is ignored.
REQ-022 On leaving EXEC2, the next state SHALL be HALTED if halt_req=1, else FETCH.
REQ-023 HALTED SHALL be terminal until rst_n asserts.
REQ-024 fetch/exec1/exec2 SHALL be decoded combinationally from state; at most one high; all low in IDLE, DIV_WAIT, HALTED.
REQ-025 stall SHALL be combinational: high in FETCH with waitrequest, DIV_WAIT with div_done=0, and EXEC2 with mem_access and waitrequest.
REQ-026 retired SHALL increment by 1 on each EXEC2 exit, including the exit into HALTED; it wraps 0xFFFFFFFF->0.
REQ-027 An 8-bit stall counter SHALL count consecutive stall cycles and clear on any non-stall cycle.
REQ-028 When the stall count reaches STALL_LIMIT while stall=1, error SHALL set and the state SHALL go to HALTED on the next edge.
REQ-029 Watchdog SHALL take priority over all other transitions in the same cycle.
REQ-030 halt_req and waitrequest asserted together in EXEC2 with mem_access=1 SHALL hold EXEC2; halt is taken on exit.
REQ-031 Unreachable state encodings SHALL recover to IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, retired=0, stall counter=0, error=0, independent of clk.
REQ-033 During reset, outputs SHALL be fetch=exec1=exec2=0 and active=1.
REQ-034 Reset asserted mid-instruction, including DIV_WAIT or HALTED, SHALL abandon the instruction without incrementing retired.

Structure
REQ-035 instcode_t (7-bit instruction codes, DIV=7, DIVU=8) and seq_state_t SHALL live in shared package cpu_pkg, also used by IR_decode consumers.
REQ-036 The watchdog stall counter SHALL be one sub-module, stall_watchdog; all other logic is flat.

Verification
REQ-037 Reset release, ADDU code (4), waitrequest=0 -> IDLE, FETCH, EXEC1, EXEC2, FETCH; retired=1 after 4 edges.
REQ-038 FETCH with waitrequest=1 for 3 cycles -> fetch high 4 cycles, stall high 3 cycles, then EXEC1.
REQ-039 DIV code (7), div_done after 5 cycles in DIV_WAIT -> stall high 5 cycles, then EXEC2, retired+1.
REQ-040 EXEC2 with mem_access=1, waitrequest=1 for 2 cycles, halt_req=1 -> 2 stall cycles, then HALTED, active=0, retired+1.
REQ-041 waitrequest stuck high in FETCH with STALL_LIMIT=255 -> error=1 and HALTED after the 255th stall cycle.
REQ-042 rst_n pulsed low mid-DIV_WAIT with retired=10 -> immediate IDLE, retired=0, error=0.
